// File: rtl/hex_7seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blanking gaps and frame-atomic loads.
// Define LEADING_ZERO_BLANK_EN to keep leading zero digits (above digit 0) dark.

module hex_7seg_decoder (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Hex nibble to active-high abcdefg, bit 6 is segment a.
  always_comb begin
    o_seg = 7'b0000000;
    case (i_nib)
      4'h0: o_seg = 7'b1111110;
      4'h1: o_seg = 7'b0110000;
      4'h2: o_seg = 7'b1101101;
      4'h3: o_seg = 7'b1111001;
      4'h4: o_seg = 7'b0110011;
      4'h5: o_seg = 7'b1011011;
      4'h6: o_seg = 7'b1011111;
      4'h7: o_seg = 7'b1110000;
      4'h8: o_seg = 7'b1111111;
      4'h9: o_seg = 7'b1111011;
      4'hA: o_seg = 7'b1110111;
      4'hB: o_seg = 7'b0011111;
      4'hC: o_seg = 7'b1001110;
      4'hD: o_seg = 7'b0111101;
      4'hE: o_seg = 7'b1001111;
      4'hF: o_seg = 7'b1000111;
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule

module hex_7seg_scan_ctrl #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500,
  parameter int CNT_W       = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_load,
  input  logic [15:0] i_value,
  output logic        o_pending,
  output logic [3:0]  o_an,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic        o_d,
  output logic        o_e,
  output logic        o_f,
  output logic        o_g,
  output logic        o_frame_done
);

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK_TICKS - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      pval_q, pval_d;
  logic             pend_q, pend_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             fd_q, fd_d;
  logic             xfer;
  logic             lit;
  logic [3:0]       nib_w;
  logic [6:0]       seg_w;

  // Scan sequencing plus pending/display hand-off.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    xfer    = 1'b0;
    if (!i_enable) begin
      state_d = S_BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
      xfer    = pend_q;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (cnt_q == B_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            xfer    = pend_q && (idx_q == 2'd0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == D_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            fd_d    = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_BLANK;
      endcase
    end
    disp_d = xfer ? pval_q : disp_q;
    pval_d = i_load ? i_value : pval_q;
    pend_d = i_load | (pend_q & ~xfer);
  end

  assign nib_w = disp_d[{idx_d, 2'b00} +: 4];

  hex_7seg_decoder u_dec (
    .i_nib (nib_w),
    .o_seg (seg_w)
  );

  // Anode/segment values for the upcoming cycle, so both flip together.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b0000000;
    lit   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_d)
      2'd1:    lit = |disp_d[15:4];
      2'd2:    lit = |disp_d[15:8];
      2'd3:    lit = |disp_d[15:12];
      default: lit = 1'b1;
    endcase
`endif
    if (state_d == S_SHOW && lit) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_w;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      disp_q  <= 16'h0000;
      pval_q  <= 16'h0000;
      pend_q  <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b0000000;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign o_pending    = pend_q;
  assign o_an         = an_q;
  assign o_a          = seg_q[6];
  assign o_b          = seg_q[5];
  assign o_c          = seg_q[4];
  assign o_d          = seg_q[3];
  assign o_e          = seg_q[2];
  assign o_f          = seg_q[1];
  assign o_g          = seg_q[0];
  assign o_frame_done = fd_q;

endmodule

// File: tb/tb_hex_7seg_scan_ctrl.sv
// Randomized bench for hex_7seg_scan_ctrl against a frame-position model.
// Honors LEADING_ZERO_BLANK_EN when the build defines it.

module tb_hex_7seg_scan_ctrl;

  localparam int DT = 4;
  localparam int BT = 2;
  localparam int SLOT = DT + BT;
  localparam int FR = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] val = 16'h0000;
  logic        o_pending, o_frame_done;
  logic [3:0]  o_an;
  logic        o_a, o_b, o_c, o_d, o_e, o_f, o_g;

  int passed = 0;
  int total = 0;

  int          m_t;
  logic        m_pend;
  logic [15:0] m_pval;
  logic [15:0] m_disp;

  hex_7seg_scan_ctrl #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT),
    .CNT_W       (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .i_load       (load),
    .i_value      (val),
    .o_pending    (o_pending),
    .o_an         (o_an),
    .o_a          (o_a),
    .o_b          (o_b),
    .o_c          (o_c),
    .o_d          (o_d),
    .o_e          (o_e),
    .o_f          (o_f),
    .o_g          (o_g),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
          7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[n];
  endfunction

  // Expected {an, abcdefg, frame_done, pending} from position in the frame.
  function automatic logic [12:0] expv();
    int p, k, w;
    logic [3:0] an;
    logic [6:0] sg;
    logic lit;
    p = m_t % FR;
    k = p / SLOT;
    w = p % SLOT;
    an = 4'b1111;
    sg = 7'b0;
    lit = (w >= BT);
`ifdef LEADING_ZERO_BLANK_EN
    if (k >= 1 && (m_disp >> (4 * k)) == 16'h0) lit = 1'b0;
`endif
    if (lit) begin
      an = ~(4'b0001 << k);
      sg = seg7(m_disp[4*k +: 4]);
    end
    return {an, sg, (m_t > 0 && p == 0), m_pend};
  endfunction

  function automatic logic [12:0] obs();
    return {o_an, o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_frame_done, o_pending};
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_pend = 1'b0;
    m_pval = 16'h0;
    m_disp = 16'h0;
  endtask

  // One clock edge with current inputs; update model; settle.
  task automatic tick();
    logic xf;
    @(posedge clk);
    if (en) m_t = m_t + 1;
    else m_t = 0;
    xf = m_pend && (!en || (m_t % FR) == BT);
    if (xf) m_disp = m_pval;
    if (load) begin
      m_pval = val;
      m_pend = 1'b1;
    end else if (xf) begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    model_reset();
    #12;
    total++;
    if (obs() !== 13'b1111_0000000_0_0)
      $display("FAIL reset got %b want %b", obs(), 13'b1111_0000000_0_0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan_zero();
    int fds;
    fds = 0;
    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_frame_done === 1'b1) fds++;
      total++;
      if (obs() !== expv())
        $display("FAIL scan0 t=%0d got %b want %b", m_t, obs(), expv());
      else passed++;
    end
    total++;
    if (fds !== 2) $display("FAIL frame_pulses got %0d want 2", fds);
    else passed++;
  endtask

  task automatic test_load_midframe();
    for (int i = 0; i < 60; i++) begin
      load = (i == 8);
      val = 16'h1A3F;
      tick();
      total++;
      if (obs() !== expv())
        $display("FAIL load1A3F t=%0d got %b want %b", m_t, obs(), expv());
      else passed++;
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      load = 1'b0;
      if (i == 2) begin load = 1'b1; val = 16'h1111; end
      if (i == 5) begin load = 1'b1; val = 16'h2222; end
      if (i > 30 && !done && (m_t % FR) == BT - 1) begin
        load = 1'b1;
        val = 16'h3333;
        done = 1'b1;
      end
      tick();
      total++;
      if (obs() !== expv())
        $display("FAIL b2b t=%0d got %b want %b", m_t, obs(), expv());
      else passed++;
    end
    load = 1'b0;
    total++;
    if (!done) $display("FAIL b2b_edge got %0d want 1", done);
    else passed++;
  endtask

  task automatic test_enable_drop();
    int n;
    n = 0;
    while ((m_t % FR) != 2 * SLOT + BT + 1 && n < 40) begin
      tick();
      n++;
      total++;
      if (obs() !== expv())
        $display("FAIL en_wait t=%0d got %b want %b", m_t, obs(), expv());
      else passed++;
    end
    for (int i = 0; i < 30; i++) begin
      en = !(i < 6);
      load = (i == 2);
      val = 16'h4C5D;
      tick();
      total++;
      if (obs() !== expv())
        $display("FAIL en_drop i=%0d got %b want %b", i, obs(), expv());
      else passed++;
    end
    load = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while ((m_t % FR) != BT + 1 && n < 40) begin
      tick();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== 13'b1111_0000000_0_0)
      $display("FAIL async_rst got %b want %b", obs(), 13'b1111_0000000_0_0);
    else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (obs() !== expv())
        $display("FAIL post_rst t=%0d got %b want %b", m_t, obs(), expv());
      else passed++;
    end
  endtask

  task automatic test_values();
    for (int i = 0; i < 100; i++) begin
      load = (i == 0) || (i == 50);
      val = (i < 50) ? 16'h0050 : 16'h0000;
      tick();
      total++;
      if (obs() !== expv())
        $display("FAIL lzb t=%0d got %b want %b", m_t, obs(), expv());
      else passed++;
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 9) == 0);
      val = 16'($urandom);
      tick();
      total++;
      if (obs() !== expv())
        $display("FAIL rand t=%0d got %b want %b", m_t, obs(), expv());
      else passed++;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load_midframe();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    test_values();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
